job_sequencer: RTL

Control FSM that sequences one job at a time through the shared processing datapath: accepts a job over a valid/ready port, arbitrates for the resource, runs a programmable-length processing phase and reports completion or error. Its `state`, `counter`, `busy`, `done` and `error_flag` outputs are the signals the formal reachability covers and assertions observe. It sits between the job request interface and the datapath/resource grant logic.

---
 rtl/job_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/job_sequencer.sv
// job_sequencer: one-job-at-a-time control FSM in front of the shared
// processing datapath. A job is accepted over a valid/ready port. The FSM
// then waits for the resource grant (or skips that wait when the job is
// flagged fast), runs a PROC phase lasting len+1 cycles, and reports either
// a one-cycle done pulse or a sticky error that is cleared by err_ack.
//
// Ports:
//   clk, rst_n           clock (posedge), asynchronous active-low reset
//   req_valid/req_ready  job request handshake (ready only in IDLE)
//   req_data/len/fast    job payload, PROC length, skip-WAIT flag (captured on accept)
//   res_grant            resource grant from arbiter
//   abort, err_ack       abort current job / acknowledge and clear an error
//   state, counter       FSM state encoding and phase counter
//   busy, done,          status decodes of the state register
//   error_flag
//   err_cause            01 timeout, 10 abort, 00 none
//   job_data             payload of the most recently accepted job
module job_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [7:0]        req_len,
  input  logic              req_fast,
  input  logic              res_grant,
  input  logic              abort,
  input  logic              err_ack,
  output logic [2:0]        state,
  output logic [7:0]        counter,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  output logic [1:0]        err_cause,
  output logic [DATA_W-1:0] job_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_WAIT   = 3'b001,
    S_ACTIVE = 3'b010,
    S_PROC   = 3'b011,
    S_DONE   = 3'b100,
    S_ERROR  = 3'b101
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_ABORT   = 2'b10;

  // Last WAIT cycle before timeout; TIMEOUT <= 256 keeps this within 8 bits.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [7:0]        len_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;

  assign accept = (state_q == S_IDLE) && req_valid;

  // The fast flag only steers the accept transition, so it is consumed
  // directly from req_fast rather than kept in a register nobody reads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) state_d = req_fast ? S_ACTIVE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_ERROR;
          cause_d = CAUSE_ABORT;
        end else if (res_grant) begin
          state_d = S_ACTIVE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_ERROR;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          state_d = S_ERROR;
          cause_d = CAUSE_ABORT;
        end else if (!res_grant) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_PROC;
          cnt_d   = len_q;
        end
      end
      S_PROC: begin
        if (abort) begin
          state_d = S_ERROR;
          cause_d = CAUSE_ABORT;
        end else if (cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_ERROR: begin
        if (err_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      if (accept) begin
        len_q  <= req_len;
        data_q <= req_data;
      end
    end
  end

  assign state      = state_q;
  assign counter    = cnt_q;
  assign err_cause  = cause_q;
  assign job_data   = data_q;
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_WAIT) || (state_q == S_ACTIVE) || (state_q == S_PROC);
  assign done       = (state_q == S_DONE);
  assign error_flag = (state_q == S_ERROR);

endmodule
